// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  data_mem_responder_if
//  Request-type encoding and the core <-> data memory request/response bundle.
//  Revision: 1.0
// ============================================================================

package data_mem_responder_pkg;
    // Bit 3 set marks a load; nonzero with bit 3 clear marks a store.
    typedef enum logic [3:0] {
        MEM_NOP = 4'h0,
        MEM_SB  = 4'h1,
        MEM_SH  = 4'h2,
        MEM_SW  = 4'h3,
        MEM_LB  = 4'h8,
        MEM_LH  = 4'h9,
        MEM_LW  = 4'hA,
        MEM_LBU = 4'hC,
        MEM_LHU = 4'hD
    } mem_inst_type_t;
endpackage

interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    mem_inst_type_t instType_i;
    logic [31:0]    dataAddress_i;
    logic [31:0]    writeData_i;
    logic [31:0]    readData_o;
    logic           ready_o;
    logic           err_o;
    logic           halted_o;
    logic [31:0]    tohost_o;

    modport master (
        output instType_i, dataAddress_i, writeData_i,
        input  readData_o, ready_o, err_o, halted_o, tohost_o
    );

    modport slave (
        input  instType_i, dataAddress_i, writeData_i,
        output readData_o, ready_o, err_o, halted_o, tohost_o
    );
endinterface

`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  data_mem_responder
//  Single-port byte-lane data memory with registered loads, zero-fill after
//  reset and a tohost halt register.
//  Revision: 1.0
// ============================================================================

module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int          DEPTH_WORDS    = 16384,
    parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input wire                  clk,
    input wire                  rst,
    data_mem_responder_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH_WORDS) << 2;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_READY  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [AW-1:0] r_clr_idx;
    logic [AW-1:0] w_clr_idx_next;
    logic [31:0]   r_rdata;
    logic [31:0]   w_rdata_next;
    logic          r_err;
    logic          w_err_next;
    logic [31:0]   r_tohost;
    logic [31:0]   w_tohost_next;

    logic [31:0]   r_mem [DEPTH_WORDS];

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        w_is_load;
    logic        w_is_store;
    logic        w_unsigned;
    logic [1:0]  w_size;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_unsigned = 1'b0;
        w_size     = SZ_B;
        case (bus.instType_i)
            MEM_LB:  begin w_is_load = 1'b1; w_size = SZ_B; end
            MEM_LH:  begin w_is_load = 1'b1; w_size = SZ_H; end
            MEM_LW:  begin w_is_load = 1'b1; w_size = SZ_W; end
            MEM_LBU: begin w_is_load = 1'b1; w_size = SZ_B; w_unsigned = 1'b1; end
            MEM_LHU: begin w_is_load = 1'b1; w_size = SZ_H; w_unsigned = 1'b1; end
            MEM_SB:  begin w_is_store = 1'b1; w_size = SZ_B; end
            MEM_SH:  begin w_is_store = 1'b1; w_size = SZ_H; end
            MEM_SW:  begin w_is_store = 1'b1; w_size = SZ_W; end
            default: ;
        endcase
    end

    logic [31:0]   w_off;
    logic          w_in_range;
    logic [AW-1:0] w_word_idx;
    logic [1:0]    w_lane;
    logic          w_tohost_hit;
    logic          w_tohost_word;
    logic          w_misalign;
    logic          w_bad;

    assign w_off        = bus.dataAddress_i - BASE_ADDR;
    assign w_in_range   = (w_off < MEM_BYTES);
    assign w_word_idx   = w_off[AW+1:2];
    assign w_lane       = bus.dataAddress_i[1:0];
    assign w_tohost_hit = (bus.dataAddress_i[31:2] == TOHOST_ADDR[31:2]);
    assign w_tohost_word = w_tohost_hit && (w_size == SZ_W);
    assign w_misalign   = ((w_size == SZ_H) && w_lane[0]) ||
                          ((w_size == SZ_W) && (w_lane != 2'b00));
    // A full-word tohost access is legal even when tohost lies outside RAM.
    assign w_bad        = w_misalign ||
                          (w_tohost_hit && !w_tohost_word) ||
                          (!w_in_range && !w_tohost_word);

    // ------------------------------------------------------------------
    // Load extraction and store lane steering
    // ------------------------------------------------------------------
    logic [31:0] w_ram_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;

    assign w_ram_word = r_mem[w_word_idx];
    assign w_byte     = w_ram_word[{w_lane, 3'b000} +: 8];
    assign w_half     = w_ram_word[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_load_ext = w_ram_word;
        case (w_size)
            SZ_B:    w_load_ext = w_unsigned ? {24'b0, w_byte}
                                             : {{24{w_byte[7]}}, w_byte};
            SZ_H:    w_load_ext = w_unsigned ? {16'b0, w_half}
                                             : {{16{w_half[15]}}, w_half};
            default: w_load_ext = w_ram_word;
        endcase
    end

    logic [3:0]  w_store_be;
    logic [31:0] w_store_data;

    always_comb begin
        w_store_be   = 4'hF;
        w_store_data = bus.writeData_i;
        case (w_size)
            SZ_B: begin
                w_store_be   = 4'b0001 << w_lane;
                w_store_data = {4{bus.writeData_i[7:0]}};
            end
            SZ_H: begin
                w_store_be   = w_lane[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{bus.writeData_i[15:0]}};
            end
            default: begin
                w_store_be   = 4'hF;
                w_store_data = bus.writeData_i;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: next state, RAM write port and registered outputs
    // ------------------------------------------------------------------
    logic [3:0]    w_mem_we;
    logic [AW-1:0] w_mem_idx;
    logic [31:0]   w_mem_wdata;

    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        w_rdata_next   = r_rdata;
        w_err_next     = 1'b0;
        w_tohost_next  = r_tohost;
        w_mem_we       = 4'h0;
        w_mem_idx      = w_word_idx;
        w_mem_wdata    = w_store_data;

        case (r_state)
            S_CLEAR: begin
                w_mem_we       = 4'hF;
                w_mem_idx      = r_clr_idx;
                w_mem_wdata    = 32'h0;
                w_clr_idx_next = r_clr_idx + AW'(1);
                if (r_clr_idx == LAST_IDX) begin
                    w_clr_idx_next = '0;
                    w_state_next   = S_READY;
                end
                if (w_is_load) begin
                    w_rdata_next = 32'h0;
                end
                w_err_next = (bus.instType_i != MEM_NOP);
            end

            S_READY, S_HALTED: begin
                if (w_is_load) begin
                    w_err_next = w_bad;
                    if (w_bad) begin
                        w_rdata_next = 32'h0;
                    end else if (w_tohost_word) begin
                        w_rdata_next = r_tohost;
                    end else begin
                        w_rdata_next = w_load_ext;
                    end
                end else if (w_is_store && (r_state == S_READY)) begin
                    // Once halted, stores are silently discarded.
                    w_err_next = w_bad;
                    if (!w_bad) begin
                        if (w_in_range) begin
                            w_mem_we = w_store_be;
                        end
                        if (w_tohost_word) begin
                            w_tohost_next = bus.writeData_i;
                            if (bus.writeData_i != 32'h0) begin
                                w_state_next = S_HALTED;
                            end
                        end
                    end
                end
            end

            default: w_state_next = S_READY;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
            r_clr_idx <= '0;
            r_rdata   <= 32'h0;
            r_err     <= 1'b0;
            r_tohost  <= 32'h0;
        end else begin
            r_state   <= w_state_next;
            r_clr_idx <= w_clr_idx_next;
            r_rdata   <= w_rdata_next;
            r_err     <= w_err_next;
            r_tohost  <= w_tohost_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (rst && w_mem_we[b]) begin
                r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
            end
        end
    end

    assign bus.readData_o = r_rdata;
    assign bus.err_o      = r_err;
    assign bus.tohost_o   = r_tohost;
    assign bus.ready_o    = (r_state != S_CLEAR);
    assign bus.halted_o   = (r_state == S_HALTED);

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
//  tb_data_mem_responder
//  Directed scoreboard bench for data_mem_responder with a 16-word RAM.
//  Revision: 1.0
// ============================================================================

module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int          DEPTH  = 16;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] TOHOST = 32'h8000_1000;

    logic clk = 1'b0;
    logic rst = 1'b0;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .BASE_ADDR      (BASE),
        .DEPTH_WORDS    (DEPTH),
        .TOHOST_ADDR    (TOHOST),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        bit          chk_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request for one cycle; expectation is queued before the edge.
    task automatic req(input mem_inst_type_t t, input logic [31:0] a, input logic [31:0] wd,
                       input string tag, input bit chk, input logic [31:0] ed, input logic ee);
        exp_t e;
        bus.instType_i    = t;
        bus.dataAddress_i = a;
        bus.writeData_i   = wd;
        e.tag      = tag;
        e.chk_data = chk;
        e.data     = ed;
        e.err      = ee;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        bus.instType_i = MEM_NOP;
        e = sb_q.pop_front();
        if (e.chk_data) check({e.tag, "/data"}, bus.readData_o, e.data);
        check({e.tag, "/err"}, {31'b0, bus.err_o}, {31'b0, e.err});
    endtask

    task automatic load(input mem_inst_type_t t, input logic [31:0] a, input string tag,
                        input logic [31:0] ed, input logic ee);
        req(t, a, 32'h0, tag, 1'b1, ed, ee);
    endtask

    task automatic store(input mem_inst_type_t t, input logic [31:0] a, input logic [31:0] wd,
                         input string tag, input logic ee);
        req(t, a, wd, tag, 1'b0, 32'h0, ee);
    endtask

    task automatic wait_ready(input int start, output int cyc);
        cyc = start;
        while (!bus.ready_o && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        bus.instType_i    = MEM_NOP;
        bus.dataAddress_i = 32'h0;
        bus.writeData_i   = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata",  bus.readData_o, 32'h0);
        check("rst_err",    {31'b0, bus.err_o}, 32'h0);
        check("rst_halted", {31'b0, bus.halted_o}, 32'h0);
        check("rst_tohost", bus.tohost_o, 32'h0);
        check("rst_ready",  {31'b0, bus.ready_o}, 32'h0);

        // Clear phase: requests are rejected, ready after DEPTH edges.
        rst = 1'b1;
        load(MEM_LW, BASE + 32'h3C, "clear_lw", 32'h0, 1'b1);
        check("clear_ready_lo", {31'b0, bus.ready_o}, 32'h0);
        req(MEM_NOP, 32'h0, 32'h0, "clear_err_end", 1'b1, 32'h0, 1'b0);
        wait_ready(2, cyc);
        check("clear_len", 32'(cyc), 32'd16);

        load(MEM_LW, BASE + 32'h3C, "post_clear_w15", 32'h0, 1'b0);
        load(MEM_LW, BASE + 32'h20, "post_clear_w8",  32'h0, 1'b0);

        // Word and lane stores.
        store(MEM_SW, BASE + 32'h08, 32'hDEAD_BEEF, "sw_08", 1'b0);
        load (MEM_LW, BASE + 32'h08, "lw_08", 32'hDEAD_BEEF, 1'b0);
        req  (MEM_NOP, 32'h0, 32'h0, "hold_nop", 1'b1, 32'hDEAD_BEEF, 1'b0);
        req  (MEM_SW, BASE + 32'h30, 32'h1111_2222, "hold_store", 1'b1, 32'hDEAD_BEEF, 1'b0);
        store(MEM_SB, BASE + 32'h09, 32'hFFFF_FF12, "sb_09", 1'b0);
        load (MEM_LW, BASE + 32'h08, "lw_after_sb", 32'hDEAD_12EF, 1'b0);
        store(MEM_SH, BASE + 32'h0A, 32'h1234_ABCD, "sh_0a", 1'b0);
        load (MEM_LW, BASE + 32'h08, "lw_after_sh", 32'hABCD_12EF, 1'b0);

        // Sign and zero extension.
        store(MEM_SW,  BASE + 32'h10, 32'h80FF_7F01, "sw_10", 1'b0);
        load (MEM_LW,  BASE + 32'h10, "lw_10_a", 32'h80FF_7F01, 1'b0);
        load (MEM_LW,  BASE + 32'h10, "lw_10_b", 32'h80FF_7F01, 1'b0);
        load (MEM_LB,  BASE + 32'h10, "lb_0",   32'h0000_0001, 1'b0);
        load (MEM_LB,  BASE + 32'h12, "lb_2",   32'hFFFF_FFFF, 1'b0);
        load (MEM_LBU, BASE + 32'h13, "lbu_3",  32'h0000_0080, 1'b0);
        load (MEM_LH,  BASE + 32'h12, "lh_2",   32'hFFFF_80FF, 1'b0);
        load (MEM_LHU, BASE + 32'h12, "lhu_2",  32'h0000_80FF, 1'b0);
        load (MEM_LH,  BASE + 32'h10, "lh_0",   32'h0000_7F01, 1'b0);
        load (MEM_LB,  BASE + 32'h11, "lb_1",   32'h0000_007F, 1'b0);

        // Error cases.
        store(MEM_SW, BASE + 32'h00, 32'hCAFE_F00D, "sw_00", 1'b0);
        load (MEM_LW, BASE + 32'h02, "lw_misalign", 32'h0, 1'b1);
        req  (MEM_NOP, 32'h0, 32'h0, "err_pulse_end", 1'b1, 32'h0, 1'b0);
        store(MEM_SH, BASE + 32'h05, 32'h0000_FFFF, "sh_misalign", 1'b1);
        load (MEM_LW, BASE + 32'h04, "lw_after_bad_sh", 32'h0, 1'b0);
        load (MEM_LW, 32'h7FFF_FFFC, "lw_below_base", 32'h0, 1'b1);
        store(MEM_SW, BASE + 32'h40, 32'h1234_5678, "sw_beyond", 1'b1);
        load (MEM_LW, BASE + 32'h40, "lw_beyond", 32'h0, 1'b1);
        load (MEM_LW, BASE + 32'h00, "lw_no_alias", 32'hCAFE_F00D, 1'b0);
        store(MEM_SW, BASE + 32'h3C, 32'h0000_0077, "sw_last", 1'b0);
        load (MEM_LW, BASE + 32'h3C, "lw_last", 32'h0000_0077, 1'b0);

        // Halt register.
        store(MEM_SW, TOHOST, 32'h0, "tohost_zero", 1'b0);
        check("tohost_zero_val",    bus.tohost_o, 32'h0);
        check("tohost_zero_halted", {31'b0, bus.halted_o}, 32'h0);
        store(MEM_SB, TOHOST + 32'h1, 32'h0000_00FF, "tohost_sb", 1'b1);
        check("tohost_sb_val", bus.tohost_o, 32'h0);
        check("tohost_sb_halted", {31'b0, bus.halted_o}, 32'h0);
        store(MEM_SW, TOHOST, 32'h1, "tohost_one", 1'b0);
        check("tohost_one_val",    bus.tohost_o, 32'h1);
        check("tohost_one_halted", {31'b0, bus.halted_o}, 32'h1);
        check("tohost_one_ready",  {31'b0, bus.ready_o}, 32'h1);
        load (MEM_LW, TOHOST, "lw_tohost", 32'h1, 1'b0);
        store(MEM_SW, BASE + 32'h00, 32'h0000_0055, "halt_sw_drop", 1'b0);
        store(MEM_SH, BASE + 32'h01, 32'h0000_0055, "halt_bad_sh_noerr", 1'b0);
        load (MEM_LB, TOHOST, "halt_lb_tohost", 32'h0, 1'b1);
        load (MEM_LW, BASE + 32'h00, "halt_lw_old", 32'hCAFE_F00D, 1'b0);

        // Asynchronous reset mid-operation, then a fresh clear.
        #2;
        rst = 1'b0;
        #1;
        check("rst2_halted", {31'b0, bus.halted_o}, 32'h0);
        check("rst2_tohost", bus.tohost_o, 32'h0);
        check("rst2_ready",  {31'b0, bus.ready_o}, 32'h0);
        check("rst2_rdata",  bus.readData_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_ready(0, cyc);
        check("rst2_clear_len", 32'(cyc), 32'd16);
        load(MEM_LW, BASE + 32'h00, "rst2_lw_00", 32'h0, 1'b0);
        load(MEM_LW, BASE + 32'h08, "rst2_lw_08", 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Single-port data/instruction memory that responds to the multicycle core's memory request interface (`instType`, `dataAddress`, `writeData` in; `readData` out). Serves byte, halfword and word loads and stores with fixed one-cycle read latency, sign- or zero-extends loads, and zero-fills itself after reset. It also implements a `tohost` halt register for test completion. It sits between the core and the top level; the top level holds the core in reset until `ready_o` rises.

## Interface
- `BASE_ADDR`, 32'h8000_0000, byte address of RAM word 0.
- `DEPTH_WORDS`, 16384, RAM depth in 32-bit words; power of two, ≥ 4.
- `TOHOST_ADDR`, 32'h8000_1000, word-aligned address of the halt register.
- `CLEAR_ON_RESET`, 1, when 1 zero-fill the RAM after reset; when 0 go straight to READY.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `instType_i` in `mem_inst_type_t`: request type. `MEM_NOP` means idle. Bit 3 set means load (LB/LH/LW/LBU/LHU). Bit 3 clear and nonzero means store (SB/SH/SW).
- `dataAddress_i` in 32: byte address.
- `writeData_i` in 32: store data, right-aligned.
- `readData_o` out 32: registered, extended load result.
- `ready_o` out 1: high in READY or HALTED.
- `err_o` out 1: registered one-cycle error pulse.
- `halted_o` out 1: high in HALTED.
- `tohost_o` out 32: last value written to `TOHOST_ADDR`.

## Operation
- States are CLEAR, READY and HALTED. Reset enters CLEAR if `CLEAR_ON_RESET`, otherwise READY.
- CLEAR behaviour:
  - The word counter `clr_idx` starts at 0 and writes 0 to RAM[`clr_idx`] every cycle.
  - At `DEPTH_WORDS-1` it writes that word, then goes to READY.
  - Requests in CLEAR are ignored. Loads return 0, and any non-NOP request pulses `err_o`.
- Address decode: `off = dataAddress_i - BASE_ADDR`. A request is in range when `off < 4*DEPTH_WORDS`. The word index is `off[…:2]` and the byte lane is `dataAddress_i[1:0]`.
- Alignment:
  - LH, LHU and SH require `addr[0]=0`.
  - LW and SW require `addr[1:0]=0`.
  - Byte accesses are always aligned.
- A misaligned request or an out-of-range request (other than a `TOHOST_ADDR` word access) has these effects:
  - The store is suppressed, or the load returns 0.
  - `err_o` pulses.
- Stores write only the addressed lanes:
  - SB writes `writeData_i[7:0]` to lane `addr[1:0]`.
  - SH writes `writeData_i[15:0]` to lanes `{addr[1],0}` and `{addr[1],1}`.
  - SW writes all four lanes.
- Loads extract the lane(s) from the stored word:
  - LB and LH sign-extend.
  - LBU and LHU zero-extend.
  - LW returns the word unmodified.
- `TOHOST_ADDR`:
  - SW to it in READY latches `tohost_o <= writeData_i` and, if the data is nonzero, moves to HALTED.
  - If the address also lies in RAM, the RAM is written as well.
  - LW from it returns `tohost_o`.
  - Byte or halfword access to it is treated as misaligned.
- HALTED: all stores are dropped with no error, loads are served normally, and the block stays there until reset.
- Only one request per cycle, so there is no read/write collision case.

## Timing
- Reset values: `readData_o=0`, `err_o=0`, `halted_o=0`, `tohost_o=0`, `clr_idx=0`. `ready_o` is 0 if `CLEAR_ON_RESET`, else 1.
- CLEAR lasts exactly `DEPTH_WORDS` cycles after reset release. `ready_o` rises on the following edge.
- Load latency is 1:
  - A request sampled at edge N gives `readData_o` valid after edge N and held until the next load is sampled.
  - NOP cycles and stores do not change `readData_o`.
  - The core re-issuing the same load in consecutive cycles (fetch, then decode) yields identical data.
- Stores commit at the sampling edge. A load of the same address issued in the next cycle returns the new data.
- `err_o` is asserted for the one cycle following the offending request, aligned with the load data slot.
- A reset asserted mid-CLEAR or mid-operation forces state, outputs and `clr_idx` to their reset values immediately. CLEAR restarts from word 0 after release. RAM contents are not guaranteed when `CLEAR_ON_RESET=0`.

## Test plan
- Clear and ready: `DEPTH_WORDS=16`, reset released → `ready_o` rises after exactly 16 cycles. An LW of `0x8000_003C` issued during CLEAR returns 0 with `err_o`. After ready, an LW of any word returns 0.
- Word and lanes:
  - SW 0xDEADBEEF to 0x8000_0008, then LW returns 0xDEADBEEF one cycle later.
  - SB 0x12 to 0x8000_0009, then LW returns 0xDEAD12EF.
  - SH 0xABCD to 0x8000_000A, then LW returns 0xABCD12EF.
- Extension, with word 0x80FF7F01 at 0x8000_0010:
  - LB at +0 → 0x00000001; LB at +2 → 0xFFFFFFFF; LBU at +3 → 0x00000080.
  - LH at +2 → 0xFFFF80FF; LHU at +2 → 0x000080FF.
- Errors:
  - LW at 0x8000_0002 → `readData_o=0`, `err_o` for one cycle.
  - SH at 0x8000_0005 → memory unchanged, `err_o` pulses.
  - LW at 0x7FFF_FFFC → 0 with `err_o`.
  - SW beyond `BASE_ADDR+4*DEPTH_WORDS` → dropped with `err_o`.
- Halt:
  - SW 0 to `TOHOST_ADDR` → `tohost_o=0`, still READY.
  - SW 1 to it → `tohost_o=1` and `halted_o=1` next cycle.
  - A following SW 0x55 to 0x8000_0000 is dropped; LW 0x8000_0000 still returns the old value.
  - Reset clears `halted_o` and `tohost_o`.
